kb_entry_acc: RTL
=================

Name: kb_entry_acc

Overview:
- Consumes the raw key code and valid level produced by the 4x4 keypad scanner (kb_4x4).
- Debounces press and release, then emits one event per accepted keystroke.
- Accumulates accepted keys as hex digits into a shift register, most recent digit in the LSBs, for display or downstream logic.
- Sits directly downstream of the scanner, upstream of the 7-segment/display path.

Parameters:
- WIDTH, 32, accumulator width in bits; must be a multiple of 4; digit capacity NDIG = WIDTH/4.
- DEBOUNCE, 16, number of consecutive stable cycles required to accept a press or a release (>=1).
- REPEAT_DELAY, 200, cycles held after acceptance before the first auto-repeat (optional feature only).
- REPEAT_PERIOD, 50, cycles between subsequent auto-repeats (optional feature only).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- key_code  input  4  key index from scanner; meaningful only while key_vld=1.
- key_vld  input  1  level; 1 while the scanner sees a key pressed.
- clr  input  1  synchronous clear of the accumulator and digit count.
- key_evt  output  1  one-cycle pulse per accepted keystroke.
- key_evt_code  output  4  code of the accepted key; held until the next event.
- value  output  WIDTH  accumulated hex digits.
- digit_cnt  output  $clog2(NDIG+1)  number of digits entered; saturates at NDIG.

Behaviour:
- One clock; reset is asynchronous and active-low, port rst_n; all state sits in flops cleared by rst_n.
- Reset values: key_evt=0, key_evt_code=0, value=0, digit_cnt=0, FSM=IDLE, counters=0.
- FSM states and transitions:
  - IDLE: key_vld=1 -> PRESS_DB; capture cand=key_code; cnt=1.
  - PRESS_DB:
    - key_vld=0 -> IDLE.
    - key_code != cand -> stay; cand=key_code; cnt=1.
    - Otherwise cnt++; when cnt reaches DEBOUNCE -> HELD, with key_evt=1 on the cycle after the DEBOUNCE-th stable sample. Latency from first stable sample to pulse is DEBOUNCE cycles.
  - HELD:
    - key_vld=0 -> REL_DB with cnt=1.
    - A code change while key_vld=1 is ignored; the first key owns the cycle until release.
  - REL_DB:
    - key_vld=1 -> HELD, no new event.
    - After DEBOUNCE consecutive key_vld=0 cycles -> IDLE.
- DEBOUNCE=1: a single valid sample is accepted; event fires on the next cycle.
- Accumulate on event: value <= {value[WIDTH-5:0], key_evt_code}; the oldest digit drops off. digit_cnt <= min(digit_cnt+1, NDIG).
- clr:
  - value=0, digit_cnt=0 next cycle.
  - clr and event in the same cycle: clr wins; the digit is not stored; key_evt and key_evt_code still update.
  - clr does not affect the FSM.
- key_evt is never asserted on two consecutive cycles.
- Scanner glitches shorter than DEBOUNCE cycles produce no event.
- Reset mid-debounce or mid-hold: immediate return to IDLE with all outputs at reset values. A key still held after reset release is debounced and accepted as a new press.

Optional Feature:
- Macro: KB_ENTRY_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter starts at acceptance.
  - After REPEAT_DELAY cycles an extra key_evt with the same code fires and is accumulated. Further events follow every REPEAT_PERIOD cycles while HELD.
  - Entering REL_DB freezes the counter. A return to HELD from REL_DB resumes the count; it does not restart.
  - Leaving to IDLE resets the counter.
- Undefined: no repeat counter logic exists; exactly one event per press.

Decomposition:
- Package kb_pkg:
  - typedef kb_code_t (logic [3:0]).
  - Enum kb_entry_state_t {IDLE, PRESS_DB, HELD, REL_DB}.
  - localparam KB_NKEYS=16.
- Sub-module kb_debounce_cnt: a generic stable-sample counter with a restart input and a done flag. It is instantiated once for press/release debounce; the repeat timer is a plain counter in the top.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with key_vld=1 -> value=0, digit_cnt=0, key_evt=0 throughout; after release, event fires DEBOUNCE=16 cycles after the first stable sample.
- Keystroke sequence: press codes 1,2,3,A, each held 100 cycles with 300-cycle gaps (kb_4x4 model timing) -> exactly 4 key_evt pulses; value=32'h0000_123A; digit_cnt=4.
- Glitch rejection: key_vld pulses 10 cycles, code 5 -> no event. Code toggling 5/6 every 8 cycles for 100 cycles -> no event. A 5-cycle release dropout while HELD -> no second event.
- Overflow: enter 9 digits 1..9 -> value=32'h2345_6789; digit_cnt=8 (saturated).
- Clear collision: assert clr on the same cycle as the key_evt for code 7 with value=32'h0000_00AB -> value=0, digit_cnt=0, key_evt=1, key_evt_code=7.
- Auto-repeat (KB_ENTRY_AUTOREPEAT_EN defined): hold code C for 16+200+2*50+5 cycles -> 4 events (initial plus 3 repeats); value=32'h0000_CCCC. With the macro undefined, the same stimulus gives 1 event.

Source files
------------

// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kb_pkg
// Purpose  : Shared types and constants for the keypad entry path.
//            kb_code_t        - 4-bit key index from the 4x4 scanner
//            kb_entry_state_t - keystroke acceptance FSM states
// Revision : 1.0  initial release
// ============================================================================
package kb_pkg;

   localparam int KB_NKEYS = 16;

   typedef logic [$clog2(KB_NKEYS)-1:0] kb_code_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kb_entry_state_t;

endpackage
`default_nettype wire

// File: rtl/kb_debounce_cnt.sv
`default_nettype none
// ============================================================================
// Module   : kb_debounce_cnt
// Purpose  : Generic stable-sample counter. restart loads a count of one
//            (the current sample is the first stable one), step adds one
//            sample, saturating at TARGET. done flags, combinationally, that
//            the sample taken this cycle completes TARGET stable samples.
// Ports    : clk, rst_n (async, active-low)
//            restart - begin a new run with this cycle's sample
//            step    - this cycle's sample extends the current run
//            done    - this cycle's sample is the TARGET-th of the run
// Revision : 1.0  initial release
// ============================================================================
module kb_debounce_cnt #(
   parameter int TARGET = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic step,
   output logic done
);

   localparam int CW = $clog2(TARGET + 1);
   localparam logic [CW-1:0] C_TARGET = CW'(TARGET);
   localparam logic [CW-1:0] C_ONE    = CW'(1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (restart)
         w_cnt_nxt = C_ONE;
      else if (step && (r_cnt != C_TARGET))
         w_cnt_nxt = r_cnt + C_ONE;
   end

   assign done = (restart || step) && (w_cnt_nxt == C_TARGET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else
         r_cnt <= w_cnt_nxt;
   end

endmodule
`default_nettype wire

// File: rtl/kb_entry_acc.sv
`default_nettype none
// ============================================================================
// Module   : kb_entry_acc
// Purpose  : Debounces the 4x4 scanner's key code / valid level, emits one
//            key_evt pulse per accepted keystroke and shifts accepted codes
//            into a hex-digit accumulator (newest digit in the LSBs).
// Ports    : clk, rst_n       - clock, async active-low reset
//            key_code/key_vld - raw scanner outputs
//            clr              - synchronous clear of value and digit_cnt
//            key_evt          - one-cycle pulse per accepted keystroke
//            key_evt_code     - code of the last accepted key
//            value            - accumulated hex digits
//            digit_cnt        - digits entered, saturating at WIDTH/4
// Options  : `define KB_ENTRY_AUTOREPEAT_EN adds auto-repeat while a key is
//            held (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD).
// Revision : 1.0  initial release
// ============================================================================
module kb_entry_acc
   import kb_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int DEBOUNCE      = 16,
   parameter int REPEAT_DELAY  = 200,
   parameter int REPEAT_PERIOD = 50
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [3:0]                      key_code,
   input  logic                            key_vld,
   input  logic                            clr,
   output logic                            key_evt,
   output logic [3:0]                      key_evt_code,
   output logic [WIDTH-1:0]                value,
   output logic [$clog2(WIDTH/4+1)-1:0]    digit_cnt
);

   localparam int NDIG = WIDTH / 4;
   localparam int CNTW = $clog2(NDIG + 1);
   localparam logic [CNTW-1:0] C_NDIG = CNTW'(NDIG);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
         $error("kb_entry_acc: WIDTH must be a multiple of 4 and at least 8");
      end
      if (DEBOUNCE < 1) begin : g_bad_debounce
         $error("kb_entry_acc: DEBOUNCE must be at least 1");
      end
      if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
         $error("kb_entry_acc: repeat intervals must be at least 2 cycles");
      end
   endgenerate

   kb_entry_state_t r_state;
   kb_entry_state_t w_state_nxt;
   kb_code_t        r_cand;
   logic            w_db_restart;
   logic            w_db_step;
   logic            w_db_done;
   logic            w_evt;
   kb_code_t        w_evt_code;

   // Counter control is decoded apart from the next-state logic so that the
   // done flag (which depends on it) never loops back into its own inputs.
   assign w_db_restart = (r_state == IDLE     &&  key_vld)
                       | (r_state == PRESS_DB &&  key_vld && key_code != r_cand)
                       | (r_state == HELD     && !key_vld);
   assign w_db_step    = (r_state == PRESS_DB &&  key_vld && key_code == r_cand)
                       | (r_state == REL_DB   && !key_vld);

   kb_debounce_cnt #(
      .TARGET (DEBOUNCE)
   ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (w_db_restart),
      .step    (w_db_step),
      .done    (w_db_done)
   );

`ifdef KB_ENTRY_AUTOREPEAT_EN
   localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   localparam logic [RW-1:0] C_RDLY = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] C_RPER = RW'(REPEAT_PERIOD);
   localparam logic [RW-1:0] C_RONE = RW'(1);

   logic [RW-1:0] r_rpt;
   logic          w_accept;

   assign w_accept = (r_state == IDLE || r_state == PRESS_DB) && (w_state_nxt == HELD);

   // Down-counter to the next repeat. It only ticks on cycles spent in HELD
   // with the key down, so a release dropout (REL_DB) freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rpt <= '0;
      else if (w_accept)
         r_rpt <= C_RDLY;
      else if (r_state == HELD && key_vld)
         r_rpt <= (r_rpt <= C_RONE) ? C_RPER : r_rpt - C_RONE;
      else if (w_state_nxt == IDLE)
         r_rpt <= '0;
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_evt       = 1'b0;
      w_evt_code  = r_cand;
      case (r_state)
         IDLE: begin
            if (key_vld) begin
               w_state_nxt = w_db_done ? HELD : PRESS_DB;
               w_evt       = w_db_done;
               w_evt_code  = key_code;
            end
         end
         PRESS_DB: begin
            if (!key_vld) begin
               w_state_nxt = IDLE;
            end else if (w_db_done) begin
               // key_code equals the candidate here, or is a fresh one that
               // was accepted on its first sample (DEBOUNCE == 1).
               w_state_nxt = HELD;
               w_evt       = 1'b1;
               w_evt_code  = key_code;
            end
         end
         HELD: begin
            if (!key_vld) begin
               w_state_nxt = w_db_done ? IDLE : REL_DB;
            end
`ifdef KB_ENTRY_AUTOREPEAT_EN
            else if (r_rpt == C_RONE) begin
               w_evt      = 1'b1;
               w_evt_code = r_cand;
            end
`endif
         end
         REL_DB: begin
            if (key_vld)
               w_state_nxt = HELD;
            else if (w_db_done)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cand  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_db_restart && key_vld)
            r_cand <= key_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_evt      <= 1'b0;
         key_evt_code <= '0;
         value        <= '0;
         digit_cnt    <= '0;
      end else begin
         key_evt <= w_evt;
         if (w_evt)
            key_evt_code <= w_evt_code;
         // clr takes priority: a digit arriving in the same cycle is dropped.
         if (clr) begin
            value     <= '0;
            digit_cnt <= '0;
         end else if (w_evt) begin
            value <= {value[WIDTH-5:0], w_evt_code};
            if (digit_cnt != C_NDIG)
               digit_cnt <= digit_cnt + CNTW'(1);
         end
      end
   end

endmodule
`default_nettype wire
